mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and its MEM-stage data port. Each requester raises a held request and receives a one-cycle done pulse with registered read data. Data accesses have priority; a starvation counter bounds how long fetch can be starved. The block sits between the pipelined cpu and the unified memory, and supplies the stall signals the pipeline's hazard logic consumes.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch and
// MEM-stage data accesses; data has priority, a starvation counter bounds fetch delay.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [3:0]  d_xfer_size,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,

    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [3:0]  m_xfer_size,
    input  logic [63:0] m_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_START  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);
    localparam logic [3:0]       FETCH_SIZE = 4'b0100;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t            state_reg,    state_next;
    owner_t            owner_reg,    owner_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;
    logic [STV_W-1:0]  starve_reg,   starve_next;
    logic              cancel_reg,   cancel_next;
    logic              m_en_reg,     m_en_next;
    logic              m_we_reg,     m_we_next;
    logic [63:0]       m_addr_reg,   m_addr_next;
    logic [63:0]       m_wdata_reg,  m_wdata_next;
    logic [3:0]        m_size_reg,   m_size_next;
    logic [31:0]       if_rdata_reg, if_rdata_next;
    logic [63:0]       d_rdata_reg,  d_rdata_next;
    logic              if_done_reg,  if_done_next;
    logic              d_done_reg,   d_done_next;

    logic              fetch_win;
    logic              data_win;
    logic              flush_hit;

    // Fetch wins outright when data is absent, or when it has been starved long
    // enough; a flush in the same cycle always withholds the fetch grant.
    assign fetch_win = if_req & ~if_flush & (~d_req | (starve_reg == STARVE_TOP));
    assign data_win  = d_req & ~fetch_win;
    assign flush_hit = (owner_reg == OWN_FETCH) & if_flush;

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        cnt_next      = cnt_reg;
        starve_next   = starve_reg;
        cancel_next   = cancel_reg;
        m_en_next     = m_en_reg;
        m_we_next     = m_we_reg;
        m_addr_next   = m_addr_reg;
        m_wdata_next  = m_wdata_reg;
        m_size_next   = m_size_reg;
        if_rdata_next = if_rdata_reg;
        d_rdata_next  = d_rdata_reg;
        if_done_next  = 1'b0;
        d_done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                cancel_next = 1'b0;
                if (fetch_win || data_win) begin
                    state_next = BUSY;
                    m_en_next  = 1'b1;
                    cnt_next   = CNT_START;
                    if (fetch_win) begin
                        owner_next  = OWN_FETCH;
                        m_we_next   = 1'b0;
                        m_addr_next = if_addr;
                        m_size_next = FETCH_SIZE;
                        starve_next = '0;
                    end else begin
                        owner_next   = OWN_DATA;
                        m_we_next    = d_we;
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                        m_size_next  = d_xfer_size;
                        if (!if_req)
                            starve_next = '0;
                        else if (starve_reg != STARVE_TOP)
                            starve_next = starve_reg + 1'b1;
                    end
                end
            end

            BUSY: begin
                if (flush_hit)
                    cancel_next = 1'b1;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    state_next = RESP;
                    m_en_next  = 1'b0;
                    m_we_next  = 1'b0;
                    if (owner_reg == OWN_DATA) begin
                        d_done_next = 1'b1;
                        if (!m_we_reg)
                            d_rdata_next = m_rdata;
                    end else if (!(cancel_reg || if_flush)) begin
                        // A flush landing on the final BUSY cycle still suppresses the result.
                        if_done_next  = 1'b1;
                        if_rdata_next = m_rdata[31:0];
                    end
                end
            end

            RESP: begin
                state_next  = IDLE;
                cancel_next = 1'b0;
            end

            default: begin
                state_next = IDLE;
                m_en_next  = 1'b0;
                m_we_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            owner_reg    <= OWN_FETCH;
            cnt_reg      <= '0;
            starve_reg   <= '0;
            cancel_reg   <= 1'b0;
            m_en_reg     <= 1'b0;
            m_we_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            m_size_reg   <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            if_done_reg  <= 1'b0;
            d_done_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            starve_reg   <= starve_next;
            cancel_reg   <= cancel_next;
            m_en_reg     <= m_en_next;
            m_we_reg     <= m_we_next;
            m_addr_reg   <= m_addr_next;
            m_wdata_reg  <= m_wdata_next;
            m_size_reg   <= m_size_next;
            if_rdata_reg <= if_rdata_next;
            d_rdata_reg  <= d_rdata_next;
            if_done_reg  <= if_done_next;
            d_done_reg   <= d_done_next;
        end
    end

    assign m_en        = m_en_reg;
    assign m_we        = m_we_reg;
    assign m_addr      = m_addr_reg;
    assign m_wdata     = m_wdata_reg;
    assign m_xfer_size = m_size_reg;
    assign if_rdata    = if_rdata_reg;
    assign if_done     = if_done_reg;
    assign d_rdata     = d_rdata_reg;
    assign d_done      = d_done_reg;
    assign if_stall    = if_req & ~if_done_reg;
    assign d_stall     = d_req & ~d_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: latency-accurate memory model,
// scoreboard of expected completions, table-driven single accesses plus corner sequences.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_xfer_size;
    logic        d_done, d_stall;
    logic        m_en, m_we;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_xfer_size;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_xfer_size(d_xfer_size), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_xfer_size(m_xfer_size), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [63:0] exp_rdata;
        logic [3:0]  exp_xsize;
    } vec_t;

    typedef struct {
        bit          is_data;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] g_addr[$];
    int          g_cyc[$];
    int          g_starve[$];
    logic [63:0] mem[logic [63:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int last_en_len = 0;
    int we_cycles = 0;
    int if_done_cyc = 0;
    int d_done_cyc = 0;
    bit prev_en = 1'b0;
    bit hold_d = 1'b0;

    function automatic logic [63:0] rd_model(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 64'h10) return 64'h0000_0000_DEAD_BEEF;
        if (a == 64'h40) return 64'h0000_0000_8B02_0020;
        return {a[31:0] ^ 32'hC0DE_0000, a[31:0] ^ 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_data, input logic [63:0] exp);
        sb_t e;
        e.is_data = is_data;
        e.exp     = exp;
        sb.push_back(e);
    endtask

    // One clock cycle: sample outputs on the falling edge, model memory and requesters.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (m_en && !prev_en) begin
            g_addr.push_back(m_addr);
            g_cyc.push_back(cyc);
            g_starve.push_back(int'(dut.starve_reg));
        end
        if (!m_en && prev_en) last_en_len = en_cnt;
        en_cnt  = m_en ? en_cnt + 1 : 0;
        prev_en = m_en;
        if (m_we) begin
            we_cycles++;
            mem[m_addr] = m_wdata;
            chk("m_we_without_m_en", {63'd0, m_en}, 64'd1);
        end
        m_rdata = (m_en && en_cnt >= L) ? rd_model(m_addr) : 64'hBADB_AD00_BADB_AD00;
        if (if_done) begin
            if_done_cyc = cyc;
            chk("if_stall_at_done", {63'd0, if_stall}, 64'd0);
            if (sb.size() == 0 || sb[0].is_data) begin
                chk("if_done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                $display("txn fetch done cycle %0d if_rdata=%h", cyc, if_rdata);
                chk("if_rdata", {32'd0, if_rdata}, {32'd0, e.exp[31:0]});
            end
            if_req = 1'b0;
            hold_d = 1'b0;
        end
        if (d_done) begin
            d_done_cyc = cyc;
            chk("d_stall_at_done", {63'd0, d_stall}, 64'd0);
            if (sb.size() == 0 || !sb[0].is_data) begin
                chk("d_done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                $display("txn data done cycle %0d d_rdata=%h", cyc, d_rdata);
                chk("d_rdata", d_rdata, e.exp);
            end
            if (!hold_d) d_req = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
            if_req = 1'b0;
            d_req  = 1'b0;
            hold_d = 1'b0;
        end
    endtask

    task automatic clear_grants();
        g_addr.delete();
        g_cyc.delete();
        g_starve.delete();
    endtask

    vec_t vt[6];
    logic [31:0] old_if;
    int c0;
    logic [63:0] st_addr[6];
    int st_starve[6];

    initial begin
        vt[0] = '{1'b0, 1'b0, 64'h40,  64'h0,   4'h0,    64'h0000_0000_8B02_0020, 4'b0100};
        vt[1] = '{1'b1, 1'b0, 64'h10,  64'h0,   4'b1000, 64'h0000_0000_DEAD_BEEF, 4'b1000};
        vt[2] = '{1'b1, 1'b1, 64'h8,   64'h123, 4'b1000, 64'h0000_0000_DEAD_BEEF, 4'b1000};
        vt[3] = '{1'b1, 1'b0, 64'h8,   64'h0,   4'b1000, 64'h0000_0000_0000_0123, 4'b1000};
        vt[4] = '{1'b0, 1'b0, 64'h44,  64'h0,   4'h0,    64'h0000_0000_1234_563C, 4'b0100};
        vt[5] = '{1'b1, 1'b0, 64'h100, 64'h0,   4'b0010, 64'hC0DE_0100_1234_5778, 4'b0010};

        reset = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_xfer_size = '0;
        m_rdata = '0;
        tick();
        tick();
        chk("rst_m_en", {63'd0, m_en}, 64'd0);
        chk("rst_m_we", {63'd0, m_we}, 64'd0);
        chk("rst_if_done", {63'd0, if_done}, 64'd0);
        chk("rst_d_done", {63'd0, d_done}, 64'd0);
        chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_xfer_size", {60'd0, m_xfer_size}, 64'd0);
        reset = 1'b0;
        tick();

        // Reset one cycle after a data grant aborts the access; it is re-granted afterwards.
        d_addr = 64'h10; d_we = 1'b0; d_xfer_size = 4'b1000; d_req = 1'b1;
        tick();
        chk("rstbusy_granted", {63'd0, m_en}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rstbusy_m_en_async", {63'd0, m_en}, 64'd0);
        tick();
        chk("rstbusy_no_done", {63'd0, d_done}, 64'd0);
        reset = 1'b0;
        push(1'b1, 64'h0000_0000_DEAD_BEEF);
        c0 = cyc;
        wait_drain(20);
        chk("rstbusy_latency", 64'(d_done_cyc - c0), 64'd3);
        tick();

        for (int i = 0; i < 6; i++) begin
            we_cycles = 0;
            if (vt[i].is_data) begin
                d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata;
                d_xfer_size = vt[i].size; d_req = 1'b1;
            end else begin
                if_addr = vt[i].addr; if_req = 1'b1;
            end
            push(vt[i].is_data, vt[i].exp_rdata);
            $display("txn vec %0d %s addr=%h we=%0d", i, vt[i].is_data ? "data" : "fetch",
                     vt[i].addr, vt[i].we);
            c0 = cyc;
            tick();
            chk("vec_m_en", {63'd0, m_en}, 64'd1);
            chk("vec_m_addr", m_addr, vt[i].addr);
            chk("vec_m_xfer_size", {60'd0, m_xfer_size}, {60'd0, vt[i].exp_xsize});
            chk("vec_stall", {63'd0, vt[i].is_data ? d_stall : if_stall}, 64'd1);
            if (vt[i].we) chk("vec_m_wdata", m_wdata, vt[i].wdata);
            wait_drain(20);
            chk("vec_latency", 64'((vt[i].is_data ? d_done_cyc : if_done_cyc) - c0), 64'd3);
            chk("vec_we_cycles", 64'(we_cycles), vt[i].we ? 64'd2 : 64'd0);
            tick();
        end

        // Simultaneous requests: data first, fetch at the next IDLE grant.
        clear_grants();
        d_we = 1'b0; d_addr = 64'h18; d_xfer_size = 4'b1000; d_req = 1'b1;
        if_addr = 64'h48; if_req = 1'b1;
        push(1'b1, 64'hC0DE_0018_1234_5660);
        push(1'b0, 64'h0000_0000_1234_5630);
        wait_drain(30);
        tick();
        if (g_addr.size() == 2) begin
            chk("simul_first", g_addr[0], 64'h18);
            chk("simul_second", g_addr[1], 64'h48);
            chk("simul_spacing", 64'(g_cyc[1] - g_cyc[0]), 64'd4);
        end else begin
            chk("simul_grant_count", 64'(g_addr.size()), 64'd2);
        end

        // Starvation: fetch held while data keeps re-requesting.
        clear_grants();
        st_addr   = '{64'h200, 64'h200, 64'h200, 64'h200, 64'h300, 64'h200};
        st_starve = '{1, 2, 3, 4, 0, 0};
        hold_d = 1'b1;
        d_we = 1'b0; d_addr = 64'h200; d_xfer_size = 4'b1000; d_req = 1'b1;
        if_addr = 64'h300; if_req = 1'b1;
        for (int i = 0; i < 6; i++)
            push(st_addr[i] == 64'h200, st_addr[i] == 64'h200 ? 64'hC0DE_0200_1234_5478
                                                               : 64'h0000_0000_1234_5578);
        wait_drain(80);
        tick();
        chk("starve_grant_count", 64'(g_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < g_addr.size(); i++) begin
            chk("starve_grant_addr", g_addr[i], st_addr[i]);
            chk("starve_counter", 64'(g_starve[i]), 64'(st_starve[i]));
        end

        // Flush one cycle into a fetch BUSY; pending data follows at the next IDLE.
        clear_grants();
        old_if = if_rdata;
        if_addr = 64'h500; if_req = 1'b1;
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        d_we = 1'b0; d_addr = 64'h600; d_xfer_size = 4'b1000; d_req = 1'b1;
        push(1'b1, 64'hC0DE_0600_1234_5078);
        tick();
        if_flush = 1'b0;
        tick();
        chk("flush_m_en_len", 64'(last_en_len), 64'd2);
        wait_drain(20);
        chk("flush_if_rdata_kept", {32'd0, if_rdata}, {32'd0, old_if});
        if (g_addr.size() == 2) begin
            chk("flush_fetch_grant", g_addr[0], 64'h500);
            chk("flush_data_grant", g_addr[1], 64'h600);
            chk("flush_spacing", 64'(g_cyc[1] - g_cyc[0]), 64'd4);
        end else begin
            chk("flush_grant_count", 64'(g_addr.size()), 64'd2);
        end
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
